// File: rtl/fpu_share_pkg.sv
// Shared types and default widths for the FPU sharing sequencer.
package fpu_share_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } fsm_state_e;

  localparam int DATA_W_DEF  = 32;
  localparam int SEL_W_DEF   = 3;
  localparam int TIMEOUT_DEF = 64;

endpackage

// File: rtl/fpu_share_ctrl_rr_arbiter.sv
// Round-robin search: first set request at or above ptr_i, wrapping around.
module rr_arbiter #(
  parameter int N  = 2,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] ptr_i,
  output logic [N-1:0]  gnt_o,
  output logic [IW-1:0] idx_o,
  output logic          any_o
);

  logic found;

  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    found = 1'b0;
    for (int k = 0; k < N; k++) begin
      if (!found && req_i[IW'((int'(ptr_i) + k) % N)]) begin
        found = 1'b1;
        gnt_o[IW'((int'(ptr_i) + k) % N)] = 1'b1;
        idx_o = IW'((int'(ptr_i) + k) % N);
      end
    end
  end

  assign any_o = |req_i;

endmodule

// File: rtl/fpu_share_ctrl.sv
// Shares one single-issue FPU between NUM_REQ requesters (IDLE->ISSUE->WAIT->RESP).
// Optional WAIT timeout enabled by defining FPU_SHARE_TIMEOUT_EN.
module fpu_share_ctrl
  import fpu_share_pkg::*;
#(
  parameter int DATA_W  = DATA_W_DEF,
  parameter int NUM_REQ = 2,
  parameter int SEL_W   = SEL_W_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic                      CLK,
  input  logic                      RSTN,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic [NUM_REQ*DATA_W-1:0] req_op1,
  input  logic [NUM_REQ*DATA_W-1:0] req_op2,
  input  logic [NUM_REQ*SEL_W-1:0]  req_sel,
  output logic [NUM_REQ-1:0]        rsp_valid,
  output logic [DATA_W-1:0]         rsp_result,
  output logic                      rsp_err,
  output logic                      busy,
  output logic [DATA_W-1:0]         fpu_op1,
  output logic [DATA_W-1:0]         fpu_op2,
  output logic [SEL_W-1:0]          fpu_sel,
  output logic                      fpu_start,
  input  logic [DATA_W-1:0]         fpu_result,
  input  logic                      fpu_valid
);

  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  if (NUM_REQ < 2 || TIMEOUT < 2) begin : g_bad_cfg
    $error("fpu_share_ctrl: NUM_REQ and TIMEOUT must both be >= 2");
  end

  fsm_state_e          state_q, state_d;
  logic [IW-1:0]       rr_ptr_q, rr_ptr_d, gidx_q, gidx_d;
  logic [DATA_W-1:0]   op1_q, op1_d, op2_q, op2_d, res_q, res_d;
  logic [SEL_W-1:0]    sel_q, sel_d;
  logic [NUM_REQ-1:0]  arb_gnt, rdy_c;
  logic [IW-1:0]       arb_idx;
  logic                arb_any;

  logic [DATA_W-1:0] op1_a [NUM_REQ];
  logic [DATA_W-1:0] op2_a [NUM_REQ];
  logic [SEL_W-1:0]  sel_a [NUM_REQ];

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_slice
    assign op1_a[i] = req_op1[i*DATA_W +: DATA_W];
    assign op2_a[i] = req_op2[i*DATA_W +: DATA_W];
    assign sel_a[i] = req_sel[i*SEL_W +: SEL_W];
  end

  rr_arbiter #(.N(NUM_REQ), .IW(IW)) u_arb (
    .req_i (req_valid),
    .ptr_i (rr_ptr_q),
    .gnt_o (arb_gnt),
    .idx_o (arb_idx),
    .any_o (arb_any)
  );

`ifdef FPU_SHARE_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0] tcnt_q, tcnt_d;
  logic          err_q, err_d;
`endif

  always_comb begin
    state_d   = state_q;
    rr_ptr_d  = rr_ptr_q;
    gidx_d    = gidx_q;
    op1_d     = op1_q;
    op2_d     = op2_q;
    sel_d     = sel_q;
    res_d     = res_q;
    rdy_c     = '0;
    rsp_valid = '0;
    fpu_start = 1'b0;
`ifdef FPU_SHARE_TIMEOUT_EN
    tcnt_d    = tcnt_q;
    err_d     = err_q;
`endif
    case (state_q)
      IDLE: begin
        rdy_c = arb_gnt;
        if (arb_any) begin
          gidx_d  = arb_idx;
          op1_d   = op1_a[arb_idx];
          op2_d   = op2_a[arb_idx];
          sel_d   = sel_a[arb_idx];
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        fpu_start = 1'b1;
        state_d   = WAIT;
`ifdef FPU_SHARE_TIMEOUT_EN
        tcnt_d    = '0;
`endif
      end
      WAIT: begin
        if (fpu_valid) begin
          res_d   = fpu_result;
          state_d = RESP;
`ifdef FPU_SHARE_TIMEOUT_EN
          err_d   = 1'b0;
        end else if (tcnt_q == CW'(TIMEOUT - 1)) begin
          // a result arriving on the last allowed cycle still wins (branch above)
          res_d   = '0;
          err_d   = 1'b1;
          state_d = RESP;
        end else begin
          tcnt_d  = tcnt_q + 1'b1;
`endif
        end
      end
      RESP: begin
        rsp_valid[gidx_q] = 1'b1;
        rr_ptr_d = (gidx_q == IW'(NUM_REQ - 1)) ? '0 : gidx_q + 1'b1;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      state_q  <= IDLE;
      rr_ptr_q <= '0;
      gidx_q   <= '0;
      op1_q    <= '0;
      op2_q    <= '0;
      sel_q    <= '0;
      res_q    <= '0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      gidx_q   <= gidx_d;
      op1_q    <= op1_d;
      op2_q    <= op2_d;
      sel_q    <= sel_d;
      res_q    <= res_d;
    end
  end

`ifdef FPU_SHARE_TIMEOUT_EN
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      tcnt_q <= '0;
      err_q  <= 1'b0;
    end else begin
      tcnt_q <= tcnt_d;
      err_q  <= err_d;
    end
  end
  assign rsp_err = err_q;
`else
  assign rsp_err = 1'b0;
`endif

  // ready is combinational off req_valid, so hold it low while reset is asserted
  assign req_ready  = RSTN ? rdy_c : '0;
  assign busy       = (state_q != IDLE);
  assign rsp_result = res_q;
  assign fpu_op1    = op1_q;
  assign fpu_op2    = op2_q;
  assign fpu_sel    = sel_q;

endmodule

// File: tb/tb_fpu_share_ctrl.sv
// Self-checking bench for fpu_share_ctrl: transaction-level model plus directed scenarios.
module tb_fpu_share_ctrl;

  localparam int DW = 32;
  localparam int N  = 2;
  localparam int SW = 3;
`ifdef FPU_SHARE_TIMEOUT_EN
  localparam int TMO = 8;
`else
  localparam int TMO = 64;
`endif

  logic            CLK = 1'b0;
  logic            RSTN = 1'b0;
  logic [N-1:0]    req_valid = '0;
  logic [N-1:0]    req_ready;
  logic [N*DW-1:0] req_op1 = '0;
  logic [N*DW-1:0] req_op2 = '0;
  logic [N*SW-1:0] req_sel = '0;
  logic [N-1:0]    rsp_valid;
  logic [DW-1:0]   rsp_result;
  logic            rsp_err;
  logic            busy;
  logic [DW-1:0]   fpu_op1, fpu_op2;
  logic [SW-1:0]   fpu_sel;
  logic            fpu_start;
  logic [DW-1:0]   fpu_result = '0;
  logic            fpu_valid = 1'b0;

  fpu_share_ctrl #(.DATA_W(DW), .NUM_REQ(N), .SEL_W(SW), .TIMEOUT(TMO)) dut (
    .CLK(CLK), .RSTN(RSTN),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_op1(req_op1), .req_op2(req_op2), .req_sel(req_sel),
    .rsp_valid(rsp_valid), .rsp_result(rsp_result), .rsp_err(rsp_err),
    .busy(busy),
    .fpu_op1(fpu_op1), .fpu_op2(fpu_op2), .fpu_sel(fpu_sel), .fpu_start(fpu_start),
    .fpu_result(fpu_result), .fpu_valid(fpu_valid)
  );

  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cycle=%0d got=%h want=%h", nm, cyc, act, exp);
    end
  endtask

  // Transaction model: one job in flight, timed by its age in cycles since the handshake.
  bit          m_active = 0, m_resp = 0, m_err = 0;
  int          m_age = 0, m_g = 0, m_ptr = 0;
  logic [31:0] m_op1 = '0, m_op2 = '0, m_res = '0;
  logic [2:0]  m_sel = '0;

  // Observed events for the directed checks.
  int          hs_cyc = 0, rsp_cyc = 0, rsp_idx = -1, rsp_total = 0;
  int          rsp_cnt [N];
  logic [31:0] rsp_res = '0;
  logic        rsp_e = 1'b0;
  int          grant_log [$];

  initial for (int i = 0; i < N; i++) rsp_cnt[i] = 0;

  always @(negedge CLK) begin
    logic [N-1:0] e_rdy, e_rv;
    int g;
    if (!RSTN) begin
      chk("rst_req_ready", 32'(req_ready), 32'd0);
      chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_fpu_start", 32'(fpu_start), 32'd0);
      chk("rst_rsp_result", rsp_result, 32'd0);
      chk("rst_rsp_err", 32'(rsp_err), 32'd0);
      chk("rst_fpu_op1", fpu_op1, 32'd0);
      chk("rst_fpu_op2", fpu_op2, 32'd0);
      chk("rst_fpu_sel", 32'(fpu_sel), 32'd0);
      m_active = 0; m_resp = 0; m_err = 0; m_ptr = 0; m_res = '0;
      m_op1 = '0; m_op2 = '0; m_sel = '0;
    end else begin
      e_rdy = '0;
      e_rv  = '0;
      g     = -1;
      if (!m_active) begin
        for (int k = 0; k < N; k++)
          if (g < 0 && req_valid[(m_ptr + k) % N]) g = (m_ptr + k) % N;
        if (g >= 0) e_rdy[g] = 1'b1;
      end
      if (m_resp) e_rv[m_g] = 1'b1;
      chk("req_ready", 32'(req_ready), 32'(e_rdy));
      chk("busy", 32'(busy), 32'(m_active));
      chk("fpu_start", 32'(fpu_start), 32'(m_active && !m_resp && m_age == 1));
      chk("rsp_valid", 32'(rsp_valid), 32'(e_rv));
      chk("rsp_result", rsp_result, m_res);
      if (m_resp) chk("rsp_err", 32'(rsp_err), 32'(m_err));
      if (m_active) begin
        chk("fpu_op1", fpu_op1, m_op1);
        chk("fpu_op2", fpu_op2, m_op2);
        chk("fpu_sel", 32'(fpu_sel), 32'(m_sel));
      end
      // observation log
      if (|(req_ready & req_valid)) begin
        hs_cyc = cyc;
        for (int j = 0; j < N; j++) if (req_ready[j] && req_valid[j]) grant_log.push_back(j);
      end
      if (|rsp_valid) begin
        rsp_total++;
        rsp_cyc = cyc;
        rsp_res = rsp_result;
        rsp_e   = rsp_err;
        for (int j = 0; j < N; j++) if (rsp_valid[j]) begin rsp_idx = j; rsp_cnt[j]++; end
      end
      // advance model to next cycle
      if (!m_active) begin
        if (g >= 0) begin
          m_active = 1; m_age = 1; m_g = g;
          m_op1 = req_op1[g*DW +: DW];
          m_op2 = req_op2[g*DW +: DW];
          m_sel = req_sel[g*SW +: SW];
        end
      end else if (m_resp) begin
        m_active = 0; m_resp = 0;
        m_ptr = (m_g + 1) % N;
      end else begin
        if (m_age >= 2 && fpu_valid) begin
          m_res = fpu_result; m_err = 0; m_resp = 1;
        end
`ifdef FPU_SHARE_TIMEOUT_EN
        else if (m_age - 2 == TMO - 1) begin
          m_res = '0; m_err = 1; m_resp = 1;
        end
`endif
        m_age++;
      end
    end
  end

  task automatic tick();
    @(posedge CLK); #1;
  endtask

  task automatic nwait();
    @(negedge CLK); #1;
  endtask

  task automatic do_reset(input int n);
    req_valid = '0; fpu_valid = 1'b0;
    RSTN = 1'b0;
    repeat (n) tick();
    RSTN = 1'b1;
  endtask

  task automatic wait_start();
    int n = 0;
    nwait();
    while (!fpu_start && n < 100) begin nwait(); n++; end
    chk("start_seen", 32'(fpu_start), 32'd1);
  endtask

  // FPU stand-in: answers L cycles after the start pulse; returns in the RESP cycle
  task automatic fpu_answer(input int L, input logic [31:0] r);
    wait_start();
    repeat (L) @(posedge CLK);
    #1 fpu_valid = 1'b1; fpu_result = r;
    tick();
    fpu_valid = 1'b0;
  endtask

  task automatic wait_rsp(input int old);
    int n = 0;
    while (rsp_total == old && n < 2000) begin nwait(); n++; end
    chk("rsp_seen", 32'(rsp_total != old), 32'd1);
  endtask

  initial begin
    int old;
    do_reset(3);

    // single request, L=3
    tick();
    req_op1[31:0] = 32'h3F800000; req_op2[31:0] = 32'h40000000; req_sel[2:0] = 3'd0;
    req_valid = 2'b01;
    old = rsp_total;
    tick();
    req_valid = '0;
    req_op1[31:0] = 32'hDEADBEEF;
    fpu_answer(3, 32'h40400000);
    chk("t1_op1_hold", fpu_op1, 32'h3F800000);
    chk("t1_op2_hold", fpu_op2, 32'h40000000);
    wait_rsp(old);
    chk("t1_latency", 32'(rsp_cyc - hs_cyc), 32'd5);
    chk("t1_result", rsp_res, 32'h40400000);
    chk("t1_rsp_idx", 32'(rsp_idx), 32'd0);
    chk("t1_no_rsp1", 32'(rsp_cnt[1]), 32'd0);

    // contention: both held valid from reset
    do_reset(2);
    tick();
    grant_log.delete();
    req_op1 = {32'h00000002, 32'h00000001};
    req_valid = 2'b11;
    for (int i = 0; i < 4; i++) begin
      old = rsp_total;
      fpu_answer(1, 32'h100 + 32'(i));
      if (i == 3) req_valid = '0;
      wait_rsp(old);
      chk("t2_result", rsp_res, 32'h100 + 32'(i));
    end
    chk("t2_ngrants", 32'(grant_log.size()), 32'd4);
    for (int i = 0; i < 4 && i < grant_log.size(); i++)
      chk("t2_grant_order", 32'(grant_log[i]), 32'(i % 2));
    nwait(); nwait();
    chk("t2_busy_low", 32'(busy), 32'd0);

    // stray fpu_valid in IDLE, handshake cycle and ISSUE
    tick();
    fpu_valid = 1'b1; fpu_result = 32'hBAD0BAD0;
    tick();
    req_op1[63:32] = 32'h11; req_valid = 2'b10;
    old = rsp_total;
    tick();
    req_valid = '0;
    tick();
    fpu_valid = 1'b0;
    repeat (5) tick();
    nwait();
    chk("t3_still_busy", 32'(busy), 32'd1);
    chk("t3_no_rsp", 32'(rsp_total - old), 32'd0);
    @(posedge CLK); #1 fpu_valid = 1'b1; fpu_result = 32'h55;
    tick();
    fpu_valid = 1'b0;
    wait_rsp(old);
    chk("t3_result", rsp_res, 32'h55);
    chk("t3_rsp_idx", 32'(rsp_idx), 32'd1);

    // reset during WAIT; first move rr_ptr to 1
    tick();
    req_op1[31:0] = 32'h77; req_valid = 2'b01;
    old = rsp_total;
    fpu_answer(2, 32'h7777);
    req_valid = '0;
    wait_rsp(old);
    tick();
    req_valid = 2'b01;
    wait_start();
    tick();
    req_valid = '0;
    tick();
    old = rsp_total;
    RSTN = 1'b0;
    tick();
    nwait();
    chk("t4_rst_busy", 32'(busy), 32'd0);
    tick();
    RSTN = 1'b1;
    fpu_valid = 1'b1; fpu_result = 32'hCAFE;
    tick();
    fpu_valid = 1'b0;
    repeat (3) tick();
    chk("t4_no_rsp", 32'(rsp_total - old), 32'd0);
    req_valid = 2'b11;
    nwait();
    chk("t4_grant_ptr0", 32'(req_ready), 32'd1);
    tick();
    req_valid = '0;
    old = rsp_total;
    fpu_answer(1, 32'h4242);
    wait_rsp(old);
    chk("t4_rsp_idx", 32'(rsp_idx), 32'd0);
    chk("t4_result", rsp_res, 32'h4242);

`ifdef FPU_SHARE_TIMEOUT_EN
    // FPU never answers: error response 8 cycles after entering WAIT
    tick();
    req_valid = 2'b10;
    old = rsp_total;
    tick();
    req_valid = '0;
    wait_rsp(old);
    chk("t5_tmo_latency", 32'(rsp_cyc - hs_cyc), 32'd10);
    chk("t5_tmo_result", rsp_res, 32'd0);
    chk("t5_tmo_err", 32'(rsp_e), 32'd1);
    // answer on the last allowed WAIT cycle wins
    tick();
    req_valid = 2'b10;
    old = rsp_total;
    fpu_answer(8, 32'h99);
    req_valid = '0;
    wait_rsp(old);
    chk("t5_late_latency", 32'(rsp_cyc - hs_cyc), 32'd10);
    chk("t5_late_result", rsp_res, 32'h99);
    chk("t5_late_err", 32'(rsp_e), 32'd0);
`else
    // no timeout: WAIT is unbounded
    tick();
    req_valid = 2'b01;
    old = rsp_total;
    tick();
    req_valid = '0;
    repeat (1000) tick();
    nwait();
    chk("t5_still_busy", 32'(busy), 32'd1);
    chk("t5_no_rsp", 32'(rsp_total - old), 32'd0);
    do_reset(2);
`endif

    repeat (3) tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog cycle=%0d got=timeout want=finish", cyc);
    $fatal(1, "watchdog");
  end

endmodule
